popcount_sequencer: RTL and testbench

POPCOUNT_SEQUENCER -- requirements
Module: popcount_sequencer

---
 rtl/popcount_sequencer.sv | 118 +++++++++++
 tb/tb_popcount_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_sequencer.sv
// Counts the ones in a WIDTH-bit word, one 5-bit slice per cycle, with valid/ready handshakes.
// Define POPCOUNT_SEQ_OUTREG_EN to insert a registered output stage (OSTG) before DONE.
module popcount_sequencer #(
  parameter int WIDTH = 40
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+1)-1:0]   out_count,
  output logic                         busy
);

  localparam int NS = WIDTH / 5;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
`ifdef POPCOUNT_SEQ_OUTREG_EN
    OSTG = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [4:0]       slice;
  logic [2:0]       slice_pc;
  logic             last_slice;

  function automatic logic [2:0] pop5(input logic [4:0] s);
    pop5 = {2'b0, s[0]} + {2'b0, s[1]} + {2'b0, s[2]} + {2'b0, s[3]} + {2'b0, s[4]};
  endfunction

  assign slice      = data_q[int'(idx_q)*5 +: 5];
  assign slice_pc   = pop5(slice);
  assign last_slice = (idx_q == IW'(NS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = RUN;
`ifdef POPCOUNT_SEQ_OUTREG_EN
      RUN:  if (last_slice) state_d = OSTG;
      OSTG: state_d = DONE;
`else
      RUN:  if (last_slice) state_d = DONE;
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on acceptance, accumulate one slice per RUN cycle.
  always_comb begin
    data_d = data_q;
    acc_d  = acc_q;
    idx_d  = idx_q;
    if (state_q == IDLE && in_valid) begin
      data_d = in_data;
      acc_d  = '0;
      idx_d  = '0;
    end else if (state_q == RUN) begin
      acc_d = acc_q + CW'(slice_pc);
      idx_d = last_slice ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
    end else begin
      data_q <= data_d;
      acc_q  <= acc_d;
      idx_q  <= idx_d;
    end
  end

`ifdef POPCOUNT_SEQ_OUTREG_EN
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == OSTG) cnt_d = acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
`ifdef POPCOUNT_SEQ_OUTREG_EN
    out_count = cnt_q;
`else
    out_count = acc_q;
`endif
  end

endmodule

// File: tb/tb_popcount_sequencer.sv
// Scoreboard bench for popcount_sequencer at WIDTH=40; follows POPCOUNT_SEQ_OUTREG_EN for latency.
module tb_popcount_sequencer;

  localparam int WIDTH = 40;
  localparam int NS    = WIDTH / 5;
  localparam int CW    = $clog2(WIDTH + 1);
`ifdef POPCOUNT_SEQ_OUTREG_EN
  localparam int LAT = NS + 1;
  localparam int II  = NS + 3;
`else
  localparam int LAT = NS;
  localparam int II  = NS + 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    out_count;
  logic             busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_q[$];

  popcount_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word, wait for acceptance; returns 1 ns after the accepting edge.
  task automatic accept(input logic [WIDTH-1:0] d);
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    total_cnt++;
    if (!in_ready) $display("FAIL accept_wait: in_ready=%0b required 1", in_ready);
    else pass_cnt++;
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back($countones(d));
    tick();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL accepted_busy: busy=%0b required 1", busy);
    else pass_cnt++;
  endtask

  // Called right after accept(): checks latency, count, hold under backpressure, handoff.
  task automatic collect(input int hold);
    int lat = 0;
    int exp;
    logic [CW-1:0] first;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    total_cnt++;
    if (lat !== LAT) $display("FAIL latency: edges=%0d required %0d", lat, LAT);
    else pass_cnt++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    total_cnt++;
    if (int'(out_count) !== exp) $display("FAIL count: out_count=%0d required %0d", out_count, exp);
    else pass_cnt++;
    first = out_count;
    for (int i = 0; i < hold; i++) begin
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_count !== first || in_ready !== 1'b0)
        $display("FAIL hold: out_valid=%0b out_count=%0d in_ready=%0b required 1/%0d/0",
                 out_valid, out_count, in_ready, first);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL handoff: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_count !== '0)
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b busy=%0b out_count=%0d required 1/0/0/0",
               in_ready, out_valid, busy, out_count);
    else pass_cnt++;
    // Acceptance must work on the very first edge after release.
    in_valid = 1'b1;
    in_data  = {WIDTH{1'b1}};
    rst_n    = 1'b1;
    exp_q.push_back(WIDTH);
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL first_edge_accept: busy=%0b required 1", busy);
    else pass_cnt++;
    collect(0);
  endtask

  task automatic test_patterns();
    accept('0);
    collect(0);
    accept(40'h55_5555_5555);
    collect(1);
    accept(40'h80_0000_0001);
    collect(0);
    for (int i = 0; i < 4; i++) begin
      accept({$urandom, $urandom});
      collect(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] held;
    accept(40'hF0_F0F0_F0F0);
    while (!out_valid) tick();
    held = out_count;
    total_cnt++;
    if (held !== CW'(20)) $display("FAIL bp_count: out_count=%0d required 20", held);
    else pass_cnt++;
    void'(exp_q.pop_front());
    in_valid = 1'b1;
    in_data  = 40'h00_0000_0007;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_count !== held || in_ready !== 1'b0)
        $display("FAIL bp_hold: out_valid=%0b out_count=%0d in_ready=%0b required 1/%0d/0",
                 out_valid, out_count, in_ready, held);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_no_accept_in_done: busy=%0b in_ready=%0b out_valid=%0b required 0/1/0",
               busy, in_ready, out_valid);
    else pass_cnt++;
    exp_q.push_back(3);
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL bp_accept_after: busy=%0b required 1", busy);
    else pass_cnt++;
    collect(0);
  endtask

  task automatic test_mid_reset();
    accept({WIDTH{1'b1}});
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL mid_reset: out_valid=%0b in_ready=%0b busy=%0b required 0/1/0",
               out_valid, in_ready, busy);
    else pass_cnt++;
    void'(exp_q.pop_back());
    tick();
    rst_n = 1'b1;
    accept(40'hFF);
    collect(0);
  endtask

  task automatic test_back_to_back();
    int acc_edge[2];
    int n_acc = 0;
    logic prev_ready;
    logic [WIDTH-1:0] w[2];
    int exp;
    w[0] = 40'h12_3456_789A;
    w[1] = 40'hFF_0000_FFFF;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = w[0];
    for (int cyc = 1; cyc < 80; cyc++) begin
      prev_ready = in_ready;
      tick();
      if (prev_ready && n_acc < 2) begin
        exp_q.push_back($countones(in_data));
        acc_edge[n_acc] = cyc;
        n_acc++;
        if (n_acc == 2) in_valid = 1'b0;
        else in_data = w[1];
      end
      if (out_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        total_cnt++;
        if (int'(out_count) !== exp) $display("FAIL b2b_count: out_count=%0d required %0d", out_count, exp);
        else pass_cnt++;
      end
      if (n_acc == 2 && exp_q.size() == 0) break;
    end
    out_ready = 1'b0;
    total_cnt++;
    if (n_acc !== 2 || acc_edge[1] - acc_edge[0] !== II)
      $display("FAIL b2b_interval: accepts=%0d gap=%0d required 2/%0d",
               n_acc, acc_edge[1] - acc_edge[0], II);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL b2b_drain: pending=%0d required 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
